// File: rtl/rggen_apb_register_bridge_if.sv
// APB3/APB4 bus bundle between an APB master and the register bridge.
// The master modport drives the request side; the slave modport answers it.
interface rggen_apb_register_bridge_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_register_bridge.sv
// APB slave that broadcasts one register request to N register blocks and
// folds their active/ready/status/read_data back into a single APB response.
module rggen_apb_register_bridge #(
  parameter int                   ADDRESS_WIDTH     = 8,
  parameter int                   BUS_WIDTH         = 32,
  parameter int                   REGISTERS         = 1,
  parameter bit                   ERROR_STATUS      = 1'b0,
  parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0,
  parameter int                   TIMEOUT_CYCLES    = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  rggen_apb_register_bridge_if.slave     apb_if,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);
  localparam int STRB_WIDTH  = BUS_WIDTH / 8;
  localparam int LSB         = $clog2(STRB_WIDTH);
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX    = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_LAST   = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;
  localparam logic [1:0]               ACCESS_READ  = 2'b10;
  localparam logic [1:0]               ACCESS_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [BUS_WIDTH-1:0]     strobe_q, strobe_d;
  logic [BUS_WIDTH-1:0]     prdata_q, prdata_d;
  logic                     pslverr_q, pslverr_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;

  logic [REGISTERS-1:0] hit;
  logic [BUS_WIDTH-1:0] hit_data;
  logic                 hit_error;
  logic [BUS_WIDTH-1:0] strobe_bits;
  logic                 unused_apb;

  // Protection and the enable phase carry no information this bridge needs.
  assign unused_apb = ^{apb_if.pprot, apb_if.penable};

  assign hit = i_register_active & i_register_ready;

  // OR-folding keeps the response defined even when a broken map hits twice.
  always_comb begin
    hit_data  = '0;
    hit_error = 1'b0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (hit[i]) begin
        hit_data  = hit_data | i_register_read_data[i*BUS_WIDTH+:BUS_WIDTH];
        hit_error = hit_error | i_register_status[2*i+1];
      end
    end
  end

  always_comb begin
    strobe_bits = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strobe_bits[8*i+:8] = {8{apb_if.pstrb[i]}};
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (apb_if.psel) begin
          access_d     = apb_if.pwrite ? ACCESS_WRITE : ACCESS_READ;
          address_d    = apb_if.paddr & ADDRESS_MASK;
          write_data_d = apb_if.pwrite ? apb_if.pwdata : '0;
          strobe_d     = apb_if.pwrite ? strobe_bits : '0;
          valid_d      = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (count_q != COUNT_MAX) begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
        if (|hit) begin
          prdata_d  = hit_data;
          pslverr_d = hit_error;
          valid_d   = 1'b0;
          state_d   = RESP;
        end else if (~|i_register_active) begin
          prdata_d  = (access_q == ACCESS_WRITE) ? '0 : DEFAULT_READ_DATA;
          pslverr_d = ERROR_STATUS;
          valid_d   = 1'b0;
          state_d   = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (count_q == COUNT_LAST)) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      count_q      <= count_d;
    end
  end

  assign apb_if.pready  = (state_q == RESP);
  assign apb_if.pslverr = (state_q == RESP) & pslverr_q;
  assign apb_if.prdata  = prdata_q;

  assign o_register_valid      = valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;
endmodule

// File: tb/tb_rggen_apb_register_bridge.sv
// Self-checking bench: three modelled register blocks, a vector table for the
// single-transfer cases and hand-written sequences for reset and back-to-back.
module tb_rggen_apb_register_bridge;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int N  = 3;

  logic          clk;
  logic          rst_n;
  logic          reg_valid;
  logic [1:0]    reg_access;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_wdata;
  logic [BW-1:0] reg_strobe;
  logic [N-1:0]  reg_active;
  logic [N-1:0]  reg_ready;
  logic [2*N-1:0] reg_status;
  logic [BW*N-1:0] reg_read_data;

  int checks = 0;
  int errors = 0;

  rggen_apb_register_bridge_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) apb_if ();

  rggen_apb_register_bridge #(
    .ADDRESS_WIDTH     (AW),
    .BUS_WIDTH         (BW),
    .REGISTERS         (N),
    .ERROR_STATUS      (1'b1),
    .DEFAULT_READ_DATA (32'h0000_1234),
    .TIMEOUT_CYCLES    (4)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .apb_if                (apb_if),
    .o_register_valid      (reg_valid),
    .o_register_access     (reg_access),
    .o_register_address    (reg_address),
    .o_register_write_data (reg_wdata),
    .o_register_strobe     (reg_strobe),
    .i_register_active     (reg_active),
    .i_register_ready      (reg_ready),
    .i_register_status     (reg_status),
    .i_register_read_data  (reg_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic            write;
    logic [AW-1:0]   addr;
    logic [3:0]      strb;
    logic [BW-1:0]   wdata;
    logic [N-1:0]    act;
    int              wait_n;
    logic [1:0]      status;
    logic [N-1:0][BW-1:0] rdata;
    int              exp_valid;
    logic [1:0]      exp_access;
    logic [AW-1:0]   exp_addr;
    logic [BW-1:0]   exp_wdata;
    logic [BW-1:0]   exp_strobe;
    logic [BW-1:0]   exp_prdata;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic [BW-1:0] prdata;
    logic          err;
    int            valid_n;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic write, input logic [AW-1:0] addr, input logic [3:0] strb,
                              input logic [BW-1:0] wdata, input logic [N-1:0] act, input int wait_n,
                              input logic [1:0] status, input logic [BW-1:0] rd0, input logic [BW-1:0] rd1,
                              input logic [BW-1:0] rd2, input int exp_valid, input logic [AW-1:0] exp_addr,
                              input logic [BW-1:0] exp_wdata, input logic [BW-1:0] exp_strobe,
                              input logic [BW-1:0] exp_prdata, input logic exp_err);
    vec_t v;
    v.write      = write;
    v.addr       = addr;
    v.strb       = strb;
    v.wdata      = wdata;
    v.act        = act;
    v.wait_n     = wait_n;
    v.status     = status;
    v.rdata[0]   = rd0;
    v.rdata[1]   = rd1;
    v.rdata[2]   = rd2;
    v.exp_valid  = exp_valid;
    v.exp_access = write ? 2'b11 : 2'b10;
    v.exp_addr   = exp_addr;
    v.exp_wdata  = exp_wdata;
    v.exp_strobe = exp_strobe;
    v.exp_prdata = exp_prdata;
    v.exp_err    = exp_err;
    return v;
  endfunction

  task automatic idle_bus();
    apb_if.psel    = 1'b0;
    apb_if.penable = 1'b0;
    reg_active     = '0;
    reg_ready      = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    resp_t exp;
    resp_t got;
    int    vcount = 0;
    bit    done   = 1'b0;
    @(posedge clk); #1;
    apb_if.psel    = 1'b1;
    apb_if.penable = 1'b0;
    apb_if.paddr   = v.addr;
    apb_if.pwrite  = v.write;
    apb_if.pstrb   = v.strb;
    apb_if.pwdata  = v.wdata;
    reg_active     = v.act;
    reg_ready      = '0;
    reg_status     = {N{v.status}};
    reg_read_data  = v.rdata;
    exp.prdata     = v.exp_prdata;
    exp.err        = v.exp_err;
    exp.valid_n    = v.exp_valid;
    sb.push_back(exp);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk); #1;
      apb_if.penable = 1'b1;
      if (reg_valid) begin
        check($sformatf("%s access", tag), 32'(reg_access), 32'(v.exp_access));
        check($sformatf("%s address", tag), 32'(reg_address), 32'(v.exp_addr));
        check($sformatf("%s wdata", tag), reg_wdata, v.exp_wdata);
        check($sformatf("%s strobe", tag), reg_strobe, v.exp_strobe);
        reg_ready = (vcount == v.wait_n) ? v.act : '0;
        vcount++;
      end else begin
        reg_ready = '0;
      end
      if (apb_if.pready) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected pready: got 1 expected 0", tag);
        end else begin
          got = sb.pop_front();
          check($sformatf("%s prdata", tag), apb_if.prdata, got.prdata);
          check($sformatf("%s pslverr", tag), 32'(apb_if.pslverr), 32'(got.err));
          check($sformatf("%s valid cycles", tag), 32'(vcount), 32'(got.valid_n));
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s pready timeout: got none expected pulse", tag);
    end
    idle_bus();
    @(posedge clk); #1;
    check($sformatf("%s pready pulse width", tag), 32'(apb_if.pready), 32'd0);
    check($sformatf("%s pslverr after resp", tag), 32'(apb_if.pslverr), 32'd0);
    check($sformatf("%s prdata hold", tag), apb_if.prdata, v.exp_prdata);
  endtask

  initial begin
    resp_t exp;
    resp_t got;

    rst_n          = 1'b0;
    apb_if.psel    = 1'b0;
    apb_if.penable = 1'b0;
    apb_if.paddr   = '0;
    apb_if.pprot   = 3'b000;
    apb_if.pwrite  = 1'b0;
    apb_if.pstrb   = '0;
    apb_if.pwdata  = '0;
    reg_active     = '0;
    reg_ready      = '0;
    reg_status     = '0;
    reg_read_data  = '0;

    //            wr    addr   strb     wdata          act   wt  st     rd0            rd1            rd2            nv  eaddr  ewdata         estrobe        eprdata        eerr
    vecs[0] = mk(1'b1, 8'h04, 4'b0011, 32'h0000_FFFF, 3'b010, 0, 2'b00, 32'h0,         32'h0,         32'h0,         1, 8'h04, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0,         1'b0);
    vecs[1] = mk(1'b0, 8'h08, 4'b1111, 32'hAAAA_5555, 3'b100, 3, 2'b00, 32'h0,         32'h0,         32'hDEAD_BEEF, 4, 8'h08, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[2] = mk(1'b0, 8'hFC, 4'b0000, 32'h0,         3'b000, 0, 2'b00, 32'h0,         32'h0,         32'h0,         1, 8'hFC, 32'h0,         32'h0,         32'h0000_1234, 1'b1);
    vecs[3] = mk(1'b0, 8'h0C, 4'b0000, 32'h0,         3'b001, 99, 2'b00, 32'h7777_7777, 32'h0,        32'h0,         4, 8'h0C, 32'h0,         32'h0,         32'h0,         1'b1);
    vecs[4] = mk(1'b1, 8'h07, 4'b1010, 32'h1234_5678, 3'b001, 1, 2'b10, 32'h0,         32'h0,         32'h0,         2, 8'h04, 32'h1234_5678, 32'hFF00_FF00, 32'h0,         1'b1);
    vecs[5] = mk(1'b0, 8'h10, 4'b0000, 32'h0,         3'b011, 0, 2'b01, 32'h0000_00F0, 32'h0F00_0000, 32'h0,         1, 8'h10, 32'h0,         32'h0,         32'h0F00_00F0, 1'b0);
    vecs[6] = mk(1'b1, 8'h80, 4'b1111, 32'hCAFE_0001, 3'b000, 0, 2'b00, 32'h0,         32'h0,         32'h0,         1, 8'h80, 32'hCAFE_0001, 32'hFFFF_FFFF, 32'h0,         1'b1);
    vecs[7] = mk(1'b0, 8'h18, 4'b0000, 32'h0,         3'b100, 2, 2'b11, 32'h0,         32'h0,         32'hCAFE_F00D, 3, 8'h18, 32'h0,         32'h0,         32'hCAFE_F00D, 1'b1);

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", 32'(reg_valid), 32'd0);
    check("reset pready", 32'(apb_if.pready), 32'd0);
    check("reset pslverr", 32'(apb_if.pslverr), 32'd0);
    check("reset prdata", apb_if.prdata, 32'd0);
    check("reset address", 32'(reg_address), 32'd0);
    check("reset strobe", reg_strobe, 32'd0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a BUSY phase.
    @(posedge clk); #1;
    apb_if.psel   = 1'b1;
    apb_if.paddr  = 8'h0C;
    apb_if.pwrite = 1'b0;
    reg_active    = 3'b001;
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    check("midbusy valid before reset", 32'(reg_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midbusy reset valid", 32'(reg_valid), 32'd0);
    check("midbusy reset pready", 32'(apb_if.pready), 32'd0);
    check("midbusy reset pslverr", 32'(apb_if.pslverr), 32'd0);
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: psel stays high; a request is only taken from IDLE.
    @(posedge clk); #1;
    apb_if.psel    = 1'b1;
    apb_if.penable = 1'b0;
    apb_if.paddr   = 8'h04;
    apb_if.pwrite  = 1'b1;
    apb_if.pstrb   = 4'b1111;
    apb_if.pwdata  = 32'hA5A5_A5A5;
    reg_active     = 3'b010;
    reg_status     = '0;
    reg_read_data  = '0;
    exp.prdata = 32'h0; exp.err = 1'b0; exp.valid_n = 1;
    sb.push_back(exp);
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    check("b2b first valid", 32'(reg_valid), 32'd1);
    check("b2b first address", 32'(reg_address), 32'h04);
    reg_ready     = 3'b010;
    apb_if.paddr  = 8'h08;
    apb_if.pwrite = 1'b0;
    @(posedge clk); #1;
    check("b2b first pready", 32'(apb_if.pready), 32'd1);
    got = sb.pop_front();
    check("b2b first pslverr", 32'(apb_if.pslverr), 32'(got.err));
    check("b2b first prdata", apb_if.prdata, got.prdata);
    check("b2b address ignored while busy", 32'(reg_address), 32'h04);
    check("b2b access ignored while busy", 32'(reg_access), 32'h3);
    reg_ready     = '0;
    reg_active    = 3'b100;
    reg_status    = 6'b10_00_00;
    reg_read_data = {32'h55AA_55AA, 32'h0, 32'h0};
    exp.prdata = 32'h55AA_55AA; exp.err = 1'b1; exp.valid_n = 1;
    sb.push_back(exp);
    @(posedge clk); #1;
    apb_if.penable = 1'b0;
    check("b2b no capture in resp", 32'(reg_valid), 32'd0);
    check("b2b idle pready", 32'(apb_if.pready), 32'd0);
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    check("b2b second valid", 32'(reg_valid), 32'd1);
    check("b2b second address", 32'(reg_address), 32'h08);
    check("b2b second access", 32'(reg_access), 32'h2);
    reg_ready = 3'b100;
    @(posedge clk); #1;
    check("b2b second pready", 32'(apb_if.pready), 32'd1);
    got = sb.pop_front();
    check("b2b second pslverr", 32'(apb_if.pslverr), 32'(got.err));
    check("b2b second prdata", apb_if.prdata, got.prdata);
    idle_bus();
    @(posedge clk); #1;
    check("b2b final pready", 32'(apb_if.pready), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
